// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB maintenance sequencer: default TLB size,
// op encodings, FSM state enum and field offsets of the TLB result bus.
package tlb_pkg;

  localparam int TLB_NUM_DEFAULT = 16;

  // Op codes as issued by the execute stage; bit 1 set means a TLB write.
  typedef enum logic [1:0] {
    TLB_OP_P  = 2'b00,
    TLB_OP_R  = 2'b01,
    TLB_OP_WI = 2'b10,
    TLB_OP_WR = 2'b11
  } tlb_op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    PROBE = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } tlb_state_e;

  // Field offsets in tlb_cp0_bus_i, each field is 32 bits wide.
  localparam int BUS_W            = 160;
  localparam int FIELD_W          = 32;
  localparam int BUS_INDEX_LSB    = 0;
  localparam int BUS_PAGEMASK_LSB = 32;
  localparam int BUS_ENTRYHI_LSB  = 64;
  localparam int BUS_ENTRYLO0_LSB = 96;
  localparam int BUS_ENTRYLO1_LSB = 128;

  // Write ops (TLBWI/TLBWR) share the WRITE state.
  function automatic logic op_is_write(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/tlb_random_ctr.sv
// CP0 Random counter. Counts down from TLB_NUM-1 to Wired and wraps back,
// holds while a TLB op is in flight so TLBWR sees a stable index.
module tlb_random_ctr
  import tlb_pkg::*;
#(
  parameter int TLB_NUM = TLB_NUM_DEFAULT,
  parameter int IDX_W   = $clog2(TLB_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [IDX_W-1:0] wired,
  input  logic             wired_we,
  output logic [IDX_W-1:0] random
);

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(TLB_NUM - 1);

  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] cnt_d;

  // Next-count selection: Wired write, hold, wrap at Wired, else decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (wired_we) begin
      cnt_d = MAX_IDX;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if ((cnt_q == wired) || (wired >= MAX_IDX)) begin
      cnt_d = MAX_IDX;
    end else begin
      cnt_d = cnt_q - IDX_W'(1);
    end
  end

  // Counter register, resets to the top entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= MAX_IDX;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign random = cnt_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance op sequencer (TLBP/TLBR/TLBWI/TLBWR). Accepts one op at a
// time, emits single-cycle TLB write pulses, captures probe/read results and
// hands them to CP0 with a write-enable in the DONE cycle.
module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter int TLB_NUM = TLB_NUM_DEFAULT,
  parameter int IDX_W   = $clog2(TLB_NUM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid_i,
  input  logic [1:0]       op_i,
  output logic             op_ready_o,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic [IDX_W-1:0] wired_i,
  input  logic             wired_we_i,
  output logic [31:0]      random_o,
  output logic             tlb_write_index_o,
  output logic             tlb_write_random_o,
  input  logic [BUS_W-1:0] tlb_cp0_bus_i,
  output logic             cp0_index_we_o,
  output logic [31:0]      cp0_index_o,
  output logic             cp0_read_we_o,
  output logic [31:0]      cp0_entryhi_o,
  output logic [31:0]      cp0_entrylo0_o,
  output logic [31:0]      cp0_entrylo1_o,
  output logic [31:0]      cp0_pagemask_o
);

  tlb_state_e       state_q;
  tlb_state_e       state_d;
  tlb_state_e       state_nxt;
  logic [1:0]       op_q;
  logic [1:0]       op_d;
  logic [31:0]      index_q, index_d;
  logic [31:0]      entryhi_q, entryhi_d;
  logic [31:0]      entrylo0_q, entrylo0_d;
  logic [31:0]      entrylo1_q, entrylo1_d;
  logic [31:0]      pagemask_q, pagemask_d;
  logic             accept;
  logic             live;
  logic             hold_random;
  logic [IDX_W-1:0] random_idx;

  assign op_ready_o = (state_q == IDLE);
  assign busy_o     = (state_q != IDLE);
  assign accept     = op_valid_i && op_ready_o && !flush_i;

  // Pulses are suppressed in a flushed cycle and as soon as reset is seen.
  assign live = !rst && !flush_i;

  assign tlb_write_index_o  = live && (state_q == WRITE) && (op_q == TLB_OP_WI);
  assign tlb_write_random_o = live && (state_q == WRITE) && (op_q == TLB_OP_WR);
  assign done_o             = live && (state_q == DONE);
  assign cp0_index_we_o     = done_o && (op_q == TLB_OP_P);
  assign cp0_read_we_o      = done_o && (op_q == TLB_OP_R);

  // Freeze Random from the acceptance cycle until IDLE is re-entered.
  assign hold_random = busy_o || accept;

  tlb_random_ctr #(
    .TLB_NUM (TLB_NUM),
    .IDX_W   (IDX_W)
  ) u_random (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold_random),
    .wired    (wired_i),
    .wired_we (wired_we_i),
    .random   (random_idx)
  );

  assign random_o = {{(32 - IDX_W){1'b0}}, random_idx};

  // Next-state logic; a flush in any busy state returns straight to IDLE.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op_is_write(op_i)) begin
            state_nxt = WRITE;
          end else if (op_i == TLB_OP_R) begin
            state_nxt = READ;
          end else begin
            state_nxt = PROBE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WRITE:   state_nxt = DONE;
      PROBE:   state_nxt = DONE;
      READ:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    state_d = (flush_i && (state_q != IDLE)) ? IDLE : state_nxt;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Data capture: latch the op on accept, probe/read results one cycle later.
  always_comb begin
    op_d       = op_q;
    index_d    = index_q;
    entryhi_d  = entryhi_q;
    entrylo0_d = entrylo0_q;
    entrylo1_d = entrylo1_q;
    pagemask_d = pagemask_q;
    if (accept) begin
      op_d = op_i;
    end else begin
      op_d = op_q;
    end
    if ((state_q == PROBE) && !flush_i) begin
      index_d = tlb_cp0_bus_i[BUS_INDEX_LSB +: FIELD_W];
    end else begin
      index_d = index_q;
    end
    if ((state_q == READ) && !flush_i) begin
      pagemask_d = tlb_cp0_bus_i[BUS_PAGEMASK_LSB +: FIELD_W];
      entryhi_d  = tlb_cp0_bus_i[BUS_ENTRYHI_LSB  +: FIELD_W];
      entrylo0_d = tlb_cp0_bus_i[BUS_ENTRYLO0_LSB +: FIELD_W];
      entrylo1_d = tlb_cp0_bus_i[BUS_ENTRYLO1_LSB +: FIELD_W];
    end else begin
      pagemask_d = pagemask_q;
      entryhi_d  = entryhi_q;
      entrylo0_d = entrylo0_q;
      entrylo1_d = entrylo1_q;
    end
  end

  // Data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= 2'b00;
      index_q    <= 32'h0;
      entryhi_q  <= 32'h0;
      entrylo0_q <= 32'h0;
      entrylo1_q <= 32'h0;
      pagemask_q <= 32'h0;
    end else begin
      op_q       <= op_d;
      index_q    <= index_d;
      entryhi_q  <= entryhi_d;
      entrylo0_q <= entrylo0_d;
      entrylo1_q <= entrylo1_d;
      pagemask_q <= pagemask_d;
    end
  end

  assign cp0_index_o    = index_q;
  assign cp0_entryhi_o  = entryhi_q;
  assign cp0_entrylo0_o = entrylo0_q;
  assign cp0_entrylo1_o = entrylo1_q;
  assign cp0_pagemask_o = pagemask_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Self-checking bench for tlb_op_ctrl: per-feature tasks with a scoreboard
// queue of expected completions popped when done_o is seen.
module tb_tlb_op_ctrl;

  logic         clk = 1'b0;
  logic         rst, op_valid_i, flush_i, wired_we_i;
  logic [1:0]   op_i;
  logic [3:0]   wired_i;
  logic [159:0] tlb_cp0_bus_i;
  logic         op_ready_o, busy_o, done_o;
  logic [31:0]  random_o;
  logic         tlb_write_index_o, tlb_write_random_o;
  logic         cp0_index_we_o, cp0_read_we_o;
  logic [31:0]  cp0_index_o, cp0_entryhi_o, cp0_entrylo0_o, cp0_entrylo1_o, cp0_pagemask_o;

  typedef struct packed {
    logic [1:0]   op;
    logic [31:0]  cyc;
    logic [159:0] bus;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  tlb_op_ctrl #(.TLB_NUM(16)) dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i), .op_ready_o(op_ready_o),
    .flush_i(flush_i), .busy_o(busy_o), .done_o(done_o), .wired_i(wired_i),
    .wired_we_i(wired_we_i), .random_o(random_o), .tlb_write_index_o(tlb_write_index_o),
    .tlb_write_random_o(tlb_write_random_o), .tlb_cp0_bus_i(tlb_cp0_bus_i),
    .cp0_index_we_o(cp0_index_we_o), .cp0_index_o(cp0_index_o), .cp0_read_we_o(cp0_read_we_o),
    .cp0_entryhi_o(cp0_entryhi_o), .cp0_entrylo0_o(cp0_entrylo0_o),
    .cp0_entrylo1_o(cp0_entrylo1_o), .cp0_pagemask_o(cp0_pagemask_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] next_rand(input logic [31:0] r, input logic [3:0] w);
    return (r[3:0] == w || w == 4'd15) ? 32'd15 : r - 32'd1;
  endfunction

  task automatic test_reset();
    logic [31:0] exp_r;
    rst = 1'b1; op_valid_i = 1'b0; op_i = 2'b00; flush_i = 1'b0;
    wired_we_i = 1'b0; wired_i = 4'd0; tlb_cp0_bus_i = 160'h0;
    step(); step();
    rst = 1'b0;
    #1;
    n_tests++; if (op_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready_busy: got %b%b expected 10", op_ready_o, busy_o); end
    n_tests++; if ({done_o, tlb_write_index_o, tlb_write_random_o, cp0_index_we_o, cp0_read_we_o} !== 5'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 00000", {done_o, tlb_write_index_o, tlb_write_random_o, cp0_index_we_o, cp0_read_we_o}); end
    n_tests++; if ({cp0_index_o, cp0_entryhi_o, cp0_entrylo0_o, cp0_entrylo1_o, cp0_pagemask_o} !== 160'h0) begin
      n_fail++; $display("FAIL reset_data: got nonzero data, expected all zero"); end
    exp_r = 32'd15;
    n_tests++; if (random_o !== exp_r) begin n_fail++; $display("FAIL reset_random: got %0d expected %0d", random_o, exp_r); end
    for (int k = 0; k < 17; k++) begin
      step();
      exp_r = next_rand(exp_r, 4'd0);
      n_tests++; if (random_o !== exp_r) begin n_fail++; $display("FAIL random_seq[%0d]: got %0d expected %0d", k, random_o, exp_r); end
    end
  endtask

  task automatic test_reset_mid_op();
    op_valid_i = 1'b1; op_i = 2'b10;
    step();
    op_valid_i = 1'b0; rst = 1'b1;
    #1;
    n_tests++; if ({tlb_write_index_o, done_o} !== 2'b00) begin n_fail++; $display("FAIL rst_midop_pulse: got %b expected 00", {tlb_write_index_o, done_o}); end
    step();
    rst = 1'b0;
    #1;
    n_tests++; if ({op_ready_o, busy_o, done_o} !== 3'b100 || random_o !== 32'd15) begin
      n_fail++; $display("FAIL rst_midop_idle: got rdy/busy/done %b random %0d expected 100 / 15", {op_ready_o, busy_o, done_o}, random_o); end
  endtask

  task automatic test_tlbwi();
    exp_t e;
    op_valid_i = 1'b1; op_i = 2'b10;
    #1;
    n_tests++; if (op_ready_o !== 1'b1) begin n_fail++; $display("FAIL wi_ready_T: got %b expected 1", op_ready_o); end
    sb_q.push_back('{op: 2'b10, cyc: 32'd0, bus: 160'h0});
    step();
    op_valid_i = 1'b0;
    #1;
    n_tests++; if ({tlb_write_index_o, tlb_write_random_o, done_o, busy_o, op_ready_o} !== 5'b10010) begin
      n_fail++; $display("FAIL wi_T1: got wi/wr/done/busy/rdy %b expected 10010", {tlb_write_index_o, tlb_write_random_o, done_o, busy_o, op_ready_o}); end
    step();
    n_tests++; if ({tlb_write_index_o, tlb_write_random_o, done_o} !== 3'b001) begin
      n_fail++; $display("FAIL wi_T2: got wi/wr/done %b expected 001", {tlb_write_index_o, tlb_write_random_o, done_o}); end
    if (done_o === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_tests++; if ({cp0_index_we_o, cp0_read_we_o} !== {e.op == 2'b00, e.op == 2'b01}) begin
        n_fail++; $display("FAIL wi_we: got %b expected 00", {cp0_index_we_o, cp0_read_we_o}); end
    end
    step();
    n_tests++; if ({op_ready_o, done_o, tlb_write_random_o} !== 3'b100) begin
      n_fail++; $display("FAIL wi_T3: got rdy/done/wr %b expected 100", {op_ready_o, done_o, tlb_write_random_o}); end
    sb_q.delete();
  endtask

  task automatic test_tlbwr_wired();
    logic [31:0] exp_r;
    int n;
    wired_i = 4'd4; wired_we_i = 1'b1;
    step();
    wired_we_i = 1'b0;
    #1;
    n_tests++; if (random_o !== 32'd15) begin n_fail++; $display("FAIL wired_we_force: got %0d expected 15", random_o); end
    exp_r = 32'd15;
    for (int k = 0; k < 12; k++) begin
      step();
      exp_r = next_rand(exp_r, 4'd4);
      n_tests++; if (random_o !== exp_r) begin n_fail++; $display("FAIL wired4_seq[%0d]: got %0d expected %0d", k, random_o, exp_r); end
    end
    n = 0;
    while (random_o !== 32'd7 && n < 20) begin step(); n++; end
    n_tests++; if (n >= 20) begin n_fail++; $display("FAIL wr_wait7: got %0d expected 7 within bound", random_o); end
    op_valid_i = 1'b1; op_i = 2'b11;
    step();
    op_valid_i = 1'b0;
    #1;
    n_tests++; if ({tlb_write_random_o, tlb_write_index_o} !== 2'b10 || random_o !== 32'd7) begin
      n_fail++; $display("FAIL wr_T1: got wr/wi %b random %0d expected 10 / 7", {tlb_write_random_o, tlb_write_index_o}, random_o); end
    step();
    n_tests++; if ({done_o, cp0_index_we_o, cp0_read_we_o} !== 3'b100) begin
      n_fail++; $display("FAIL wr_T2: got done/iwe/rwe %b expected 100", {done_o, cp0_index_we_o, cp0_read_we_o}); end
    step();
    n_tests++; if (op_ready_o !== 1'b1 || random_o !== 32'd7) begin n_fail++; $display("FAIL wr_T3: got rdy %b random %0d expected 1 / 7", op_ready_o, random_o); end
    step();
    n_tests++; if (random_o !== 32'd6) begin n_fail++; $display("FAIL wr_T4_random: got %0d expected 6", random_o); end
    wired_we_i = 1'b1;
    step();
    wired_we_i = 1'b0;
    #1;
    n_tests++; if (random_o !== 32'd15) begin n_fail++; $display("FAIL wired_we_force2: got %0d expected 15", random_o); end
  endtask

  task automatic test_tlbp(input logic [31:0] v);
    exp_t e;
    op_valid_i = 1'b1; op_i = 2'b00; tlb_cp0_bus_i = {128'h0, 32'hDEAD_BEEF};
    step();
    op_valid_i = 1'b0; tlb_cp0_bus_i = {128'hFFFF, v};
    sb_q.push_back('{op: 2'b00, cyc: 32'd0, bus: tlb_cp0_bus_i});
    step();
    tlb_cp0_bus_i = {128'h0, 32'h1234_5678};
    #1;
    n_tests++; if ({done_o, cp0_index_we_o, cp0_read_we_o} !== 3'b110) begin
      n_fail++; $display("FAIL tlbp_we: got done/iwe/rwe %b expected 110", {done_o, cp0_index_we_o, cp0_read_we_o}); end
    if (done_o === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_tests++; if (cp0_index_o !== e.bus[31:0]) begin n_fail++; $display("FAIL tlbp_index: got %h expected %h", cp0_index_o, e.bus[31:0]); end
    end
    step();
    n_tests++; if (cp0_index_o !== v || op_ready_o !== 1'b1) begin n_fail++; $display("FAIL tlbp_hold: got %h rdy %b expected %h / 1", cp0_index_o, op_ready_o, v); end
    sb_q.delete();
  endtask

  task automatic test_tlbr();
    exp_t e;
    logic [31:0] old_idx;
    old_idx = cp0_index_o;
    op_valid_i = 1'b1; op_i = 2'b01; tlb_cp0_bus_i = 160'h0;
    step();
    op_valid_i = 1'b0;
    tlb_cp0_bus_i = {32'h0000_1F47, 32'h0000_0A43, 32'h1234_A012, 32'h0000_0000, 32'h0000_0009};
    sb_q.push_back('{op: 2'b01, cyc: 32'd0, bus: tlb_cp0_bus_i});
    step();
    tlb_cp0_bus_i = {160{1'b1}};
    #1;
    n_tests++; if ({done_o, cp0_index_we_o, cp0_read_we_o} !== 3'b101) begin
      n_fail++; $display("FAIL tlbr_we: got done/iwe/rwe %b expected 101", {done_o, cp0_index_we_o, cp0_read_we_o}); end
    if (done_o === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_tests++; if ({cp0_entrylo1_o, cp0_entrylo0_o, cp0_entryhi_o, cp0_pagemask_o} !== e.bus[159:32]) begin
        n_fail++; $display("FAIL tlbr_regs: got %h expected %h", {cp0_entrylo1_o, cp0_entrylo0_o, cp0_entryhi_o, cp0_pagemask_o}, e.bus[159:32]); end
      n_tests++; if (cp0_index_o !== old_idx) begin n_fail++; $display("FAIL tlbr_index_kept: got %h expected %h", cp0_index_o, old_idx); end
    end
    step();
    sb_q.delete();
  endtask

  task automatic test_flush();
    logic [31:0] r, old_idx;
    r = random_o;
    op_valid_i = 1'b1; op_i = 2'b11;
    step();
    op_valid_i = 1'b0; flush_i = 1'b1;
    #1;
    n_tests++; if ({tlb_write_random_o, tlb_write_index_o, done_o} !== 3'b000) begin
      n_fail++; $display("FAIL flush_wr_pulse: got wr/wi/done %b expected 000", {tlb_write_random_o, tlb_write_index_o, done_o}); end
    step();
    flush_i = 1'b0;
    #1;
    n_tests++; if ({busy_o, op_ready_o, done_o} !== 3'b010 || random_o !== r) begin
      n_fail++; $display("FAIL flush_idle: got busy/rdy/done %b random %0d expected 010 / %0d", {busy_o, op_ready_o, done_o}, random_o, r); end
    step();
    n_tests++; if (random_o !== next_rand(r, wired_i)) begin n_fail++; $display("FAIL flush_resume: got %0d expected %0d", random_o, next_rand(r, wired_i)); end
    old_idx = cp0_index_o;
    op_valid_i = 1'b1; op_i = 2'b00;
    step();
    op_valid_i = 1'b0; flush_i = 1'b1; tlb_cp0_bus_i = {128'h0, 32'h0000_000C};
    step();
    flush_i = 1'b0;
    #1;
    n_tests++; if (cp0_index_o !== old_idx || {done_o, cp0_index_we_o, busy_o} !== 3'b000) begin
      n_fail++; $display("FAIL flush_probe: got idx %h done/iwe/busy %b expected %h / 000", cp0_index_o, {done_o, cp0_index_we_o, busy_o}, old_idx); end
    op_valid_i = 1'b1; flush_i = 1'b1; op_i = 2'b10;
    step();
    op_valid_i = 1'b0; flush_i = 1'b0;
    #1;
    n_tests++; if (busy_o !== 1'b0 || tlb_write_index_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_block: got busy %b wi %b expected 0 0", busy_o, tlb_write_index_o); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [4];
    exp_t e;
    int k, n_done;
    ops[0] = 2'b00; ops[1] = 2'b01; ops[2] = 2'b10; ops[3] = 2'b11;
    k = 0; n_done = 0;
    tlb_cp0_bus_i = {32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003, 32'h0000_6000, 32'h0000_0003};
    for (int c = 0; c < 16; c++) begin
      op_valid_i = (k < 4); op_i = ops[k % 4];
      #1;
      if (op_valid_i && op_ready_o) begin
        n_tests++; if (c !== 3 * k) begin n_fail++; $display("FAIL b2b_accept_cycle: got %0d expected %0d", c, 3 * k); end
        sb_q.push_back('{op: ops[k], cyc: c, bus: tlb_cp0_bus_i});
        k++;
      end
      n_tests++; if ((tlb_write_index_o && tlb_write_random_o) || (cp0_index_we_o && cp0_read_we_o)) begin
        n_fail++; $display("FAIL b2b_exclusive: got wi/wr/iwe/rwe %b expected at most one per pair", {tlb_write_index_o, tlb_write_random_o, cp0_index_we_o, cp0_read_we_o}); end
      if (done_o === 1'b1) begin
        n_done++;
        if (sb_q.size() == 0) begin n_tests++; n_fail++; $display("FAIL b2b_unexpected_done: got done at %0d expected none", c); end
        else begin
          e = sb_q.pop_front();
          n_tests++; if (c !== int'(e.cyc) + 2) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d expected %0d", c, e.cyc + 2); end
          n_tests++; if ({cp0_index_we_o, cp0_read_we_o} !== {e.op == 2'b00, e.op == 2'b01}) begin
            n_fail++; $display("FAIL b2b_we op%0d: got %b expected %b", e.op, {cp0_index_we_o, cp0_read_we_o}, {e.op == 2'b00, e.op == 2'b01}); end
          if (e.op == 2'b00) begin
            n_tests++; if (cp0_index_o !== e.bus[31:0]) begin n_fail++; $display("FAIL b2b_index: got %h expected %h", cp0_index_o, e.bus[31:0]); end
          end else if (e.op == 2'b01) begin
            n_tests++; if ({cp0_entrylo1_o, cp0_entrylo0_o, cp0_entryhi_o, cp0_pagemask_o} !== e.bus[159:32]) begin
              n_fail++; $display("FAIL b2b_read: got %h expected %h", {cp0_entrylo1_o, cp0_entrylo0_o, cp0_entryhi_o, cp0_pagemask_o}, e.bus[159:32]); end
          end
        end
      end
      step();
    end
    op_valid_i = 1'b0;
    n_tests++; if (k != 4 || n_done != 4 || sb_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_totals: got accepted %0d done %0d pending %0d expected 4 4 0", k, n_done, sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_op();
    test_tlbwi();
    test_tlbwr_wired();
    test_tlbp(32'h8000_0000);
    test_tlbp(32'h0000_0005);
    test_tlbr();
    test_flush();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer for the TLB maintenance instructions (TLBP, TLBR, TLBWI, TLBWR). It sits between the execute stage and the TLB/CP0 pair. It accepts one TLB op at a time through a valid/ready handshake and produces the single-cycle write-enable pulses the TLB expects. It captures probe and read results into registers and writes them back to CP0, and it owns the CP0 Random counter used by TLBWR.

## Interface
- TLB_NUM, 16, number of TLB entries (power of two, ≥ 2)
- IDX_W, $clog2(TLB_NUM), index width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_valid_i  in  1  TLB op request from execute stage
- op_i  in  2  op code: 00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
- op_ready_o  out  1  high only in IDLE; the op is accepted when op_valid_i && op_ready_o && !flush_i
- flush_i  in  1  pipeline flush; aborts the in-flight op
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle completion pulse
- wired_i  in  IDX_W  CP0 Wired value
- wired_we_i  in  1  CP0 Wired is being written this cycle
- random_o  out  32  CP0 Random, zero-extended; feeds the TLB cp0 bus
- tlb_write_index_o  out  1  TLBWI write pulse to the TLB
- tlb_write_random_o  out  1  TLBWR write pulse to the TLB
- tlb_cp0_bus_i  in  160  TLB result bus {entrylo1, entrylo0, entryhi, pagemask, probe_index}
- cp0_index_we_o  out  1  write CP0 Index
- cp0_index_o  out  32  registered probe result
- cp0_read_we_o  out  1  write CP0 EntryHi/EntryLo0/EntryLo1/PageMask
- cp0_entryhi_o, cp0_entrylo0_o, cp0_entrylo1_o, cp0_pagemask_o  out  32 each  registered read result

## Operation
- FSM states:
  - IDLE: on accept, go to WRITE if op_i is 1x, PROBE if 00, READ if 01. The op code is latched.
  - WRITE: assert tlb_write_index_o (TLBWI) or tlb_write_random_o (TLBWR) for exactly this cycle, then go to DONE.
  - PROBE: capture tlb_cp0_bus_i[31:0] into cp0_index_o, then go to DONE.
  - READ: capture bits [159:32] into the four read registers (pagemask = [63:32], entryhi = [95:64], entrylo0 = [127:96], entrylo1 = [159:128]), then go to DONE.
  - DONE: assert done_o. Assert cp0_index_we_o if the op was TLBP, or cp0_read_we_o if it was TLBR. Then go to IDLE.
- Flush:
  - flush_i in any non-IDLE state suppresses every pulse in that cycle (write, we, done) and forces the next state to IDLE.
  - Data registers keep their old values.
  - flush_i in IDLE blocks acceptance.
- Random counter (IDX_W bits, reset TLB_NUM-1):
  - Priority 1: wired_we_i sets it to TLB_NUM-1.
  - Priority 2: if state != IDLE, it holds (the index stays stable through WRITE).
  - Priority 3: if the value equals wired_i, or wired_i ≥ TLB_NUM-1, it loads TLB_NUM-1.
  - Otherwise it decrements by 1.
  - Range is wired_i..TLB_NUM-1 with no underflow.
- At most one write pulse is high at any time. The two CP0 we outputs are never high together.

## Timing
- Reset values:
  - op_ready_o = 1
  - busy_o, done_o, both write pulses, both we outputs = 0
  - all data outputs = 0
  - random_o = TLB_NUM-1
- Cycle timeline for an op accepted in cycle T:
  - T+1: WRITE/PROBE/READ action
  - T+2: done_o and CP0 we
  - T+3: op_ready_o high again
  - Back-to-back throughput is one op per 3 cycles.
- TLBP/TLBR sample tlb_cp0_bus_i in T+1, so a CP0 EntryHi/Index write at T or earlier is visible.
- CP0 data outputs are registered. They are valid from T+2 until the next capture.
- Reset mid-op returns to IDLE next cycle; no pulses are issued after rst is asserted.

## Structure
- Shared package tlb_pkg holds:
  - the TLB_NUM default
  - op encodings TLB_OP_P / TLB_OP_R / TLB_OP_WI / TLB_OP_WR
  - the state enum IDLE/WRITE/PROBE/READ/DONE
  - bus field offsets for tlb_cp0_bus_i
- One sub-module, tlb_random_ctr, contains the Random counter with ports clk, rst, hold, wired, wired_we, random.

## Test plan
- Reset, TLB_NUM=16, wired_i=0: random_o=15 in cycle 1 after reset, then 14, 13, …, 0, then wraps to 15. op_ready_o=1 and all pulses are 0.
- TLBWI accepted at T: tlb_write_index_o=1 only at T+1, done_o=1 only at T+2, op_ready_o=1 at T+3. tlb_write_random_o stays 0 throughout.
- wired_i=4: random wraps 4→15. TLBWR accepted when random_o=7 gives tlb_write_random_o at T+1 with random_o still 7, and random_o=6 one cycle after IDLE is re-entered. A wired_we_i pulse forces random_o=15.
- TLBP with tlb_cp0_bus_i[31:0]=0x80000000 (miss), then 0x00000005 (hit): each gives cp0_index_o equal to that value and cp0_index_we_o=1 at T+2.
- TLBR with entrylo1=0x0000_1F47, entrylo0=0x0000_0A43, entryhi=0x1234_A012, pagemask=0: all four registered and cp0_read_we_o=1 at T+2.
- flush_i at T+1 of TLBWR: no write pulse, no done_o, IDLE at T+2, random resumes decrementing. flush_i in IDLE with op_valid_i: busy_o stays 0.
